// File: rtl/hps_cmd_decoder.sv
// rtl/hps_cmd_decoder.sv - HPS SPI command decoder with status/joystick/button registers and keyboard FIFO
module hps_cmd_decoder #(
    parameter logic [15:0] CORE_ID   = 16'h0000,
    parameter int          KBD_DEPTH = 8
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [15:0] io_din,
    input  logic        io_strobe,
    input  logic        io_enable,
    output logic [15:0] gp_in,
    output logic [15:0] buttons,
    output logic [31:0] joystick_0,
    output logic [31:0] status,
    output logic        status_set,
    output logic [7:0]  kbd_data,
    output logic        kbd_valid,
    input  logic        kbd_ready,
    output logic        kbd_overflow
);
    localparam int AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [7:0] CMD_BUTTONS  = 8'h01;
    localparam logic [7:0] CMD_JOY0     = 8'h02;
    localparam logic [7:0] CMD_KBD      = 8'h05;
    localparam logic [7:0] CMD_STAT_WR  = 8'h1E;
    localparam logic [7:0] CMD_STAT_RD  = 8'h1F;
    localparam logic [7:0] CMD_CORE_ID  = 8'h32;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   stage_q, stage_d;
    logic [15:0]   gp_in_q, gp_in_d;
    logic [15:0]   buttons_q, buttons_d;
    logic [31:0]   joystick_q, joystick_d;
    logic [31:0]   status_q, status_d;
    logic          status_set_q, status_set_d;
    logic [7:0]    mem_q [KBD_DEPTH];
    logic [7:0]    mem_d [KBD_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          cmd_strobe, data_strobe, push, pop, full, push_ok;
    logic [15:0]   kbd_free;

    // A falling io_enable overrides any strobe arriving in the same cycle.
    assign cmd_strobe  = (state_q == ST_CMD)  && io_enable && io_strobe;
    assign data_strobe = (state_q == ST_DATA) && io_enable && io_strobe;
    assign push        = data_strobe && (cmd_q == CMD_KBD);
    assign kbd_valid   = (count_q != '0);
    assign pop         = kbd_valid && kbd_ready;
    assign full        = (count_q == CW'(KBD_DEPTH));
    assign kbd_free    = 16'(KBD_DEPTH) - 16'(count_d);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            gp_in_q      <= '0;
            buttons_q    <= '0;
            joystick_q   <= '0;
            status_q     <= '0;
            status_set_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < KBD_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            gp_in_q      <= gp_in_d;
            buttons_q    <= buttons_d;
            joystick_q   <= joystick_d;
            status_q     <= status_d;
            status_set_q <= status_set_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!io_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD:  if (io_strobe) state_d = ST_DATA;
                ST_DATA: state_d = ST_DATA;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Full FIFO still accepts a push when the consumer pops in the same cycle.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push_ok    = push && (!full || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = io_din[7:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push && !push_ok) overflow_d = 1'b1;
    end

    always_comb begin
        cmd_d        = cmd_q;
        idx_d        = idx_q;
        stage_d      = stage_q;
        gp_in_d      = gp_in_q;
        buttons_d    = buttons_q;
        joystick_d   = joystick_q;
        status_d     = status_q;
        status_set_d = 1'b0;
        if (!io_enable) begin
            gp_in_d = '0;
            stage_d = '0;
        end else if (cmd_strobe) begin
            cmd_d   = io_din[7:0];
            idx_d   = '0;
            stage_d = '0;
            case (io_din[7:0])
                CMD_STAT_RD: gp_in_d = status_q[15:0];
                CMD_CORE_ID: gp_in_d = CORE_ID;
                CMD_KBD:     gp_in_d = kbd_free;
                default:     gp_in_d = '0;
            endcase
        end else if (data_strobe) begin
            if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
            gp_in_d = '0;
            case (cmd_q)
                CMD_BUTTONS: if (idx_q == 4'd0) buttons_d = io_din;
                CMD_JOY0: begin
                    if (idx_q == 4'd0) stage_d = io_din;
                    if (idx_q == 4'd1) joystick_d = {io_din, stage_q};
                end
                CMD_STAT_WR: begin
                    if (idx_q == 4'd0) stage_d = io_din;
                    if (idx_q == 4'd1) begin
                        status_d     = {io_din, stage_q};
                        status_set_d = 1'b1;
                    end
                end
                CMD_STAT_RD: if (idx_q == 4'd0) gp_in_d = status_q[31:16];
                CMD_KBD:     gp_in_d = kbd_free;
                default:     gp_in_d = '0;
            endcase
        end
    end

    assign gp_in        = gp_in_q;
    assign buttons      = buttons_q;
    assign joystick_0   = joystick_q;
    assign status       = status_q;
    assign status_set   = status_set_q;
    assign kbd_data     = kbd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign kbd_overflow = overflow_q;
endmodule

// File: doc/hps_cmd_decoder.md
HPS_CMD_DECODER -- requirements
Module: hps_cmd_decoder

Interface
REQ-001 Parameter CORE_ID, default 16'h0000, 16-bit identifier returned by command 0x32.
REQ-002 Parameter KBD_DEPTH, default 8, keyboard FIFO depth in entries; power of two, 2..32.
REQ-003 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_din  in  16  received SPI word from the HPS interface stage (gp_out[15:0]).
REQ-006 io_strobe  in  1  one-cycle pulse: io_din holds a newly completed word.
REQ-007 io_enable  in  1  HPS transaction frame (gp_out[20]); high for the whole command.
REQ-008 gp_in  out  16  response word, fed to the HPS interface stage for the next SPI transfer.
REQ-009 buttons  out  16  button/switch word.
REQ-010 joystick_0  out  32  joystick 0 state.
REQ-011 status  out  32  core status register.
REQ-012 status_set  out  1  one-cycle pulse on each status commit.
REQ-013 kbd_data  out  8  keyboard FIFO head byte.
REQ-014 kbd_valid  out  1  FIFO non-empty.
REQ-015 kbd_ready  in  1  consumer pop; pops when kbd_valid and kbd_ready are both high.
REQ-016 kbd_overflow  out  1  sticky: a push was dropped because the FIFO was full.

Function
REQ-017 States: IDLE, CMD, DATA; io_strobe is ignored in IDLE.
REQ-018 IDLE -> CMD when io_enable = 1.
REQ-019 CMD -> DATA on io_strobe: latch cmd = io_din[7:0] and clear word index idx to 0.
REQ-020 DATA: each io_strobe processes io_din as data word idx, then idx increments, saturating at 15.
REQ-021 io_enable = 0 in any state -> IDLE next cycle: gp_in = 0; half-written joystick/status staging discarded; committed outputs unchanged.
REQ-022 Command 0x01, idx 0: buttons <= io_din; further words ignored.
REQ-023 Command 0x02, idx 0: staged as low half; idx 1: joystick_0 <= {io_din, staged} in one cycle.
REQ-024 Command 0x1E: same two-word staging as 0x02, commits to status, status_set pulses the cycle after commit.
REQ-025 Command 0x1F (status read): gp_in = status[15:0] after the command word, status[31:16] after data word 0, 0 afterwards.
REQ-026 Command 0x05: every data word pushes io_din[7:0] into the FIFO.
REQ-027 Command 0x05, gp_in response: KBD_DEPTH minus occupancy, zero-extended, taken after the push.
REQ-028 Command 0x32: gp_in = CORE_ID after the command word, 0 afterwards.
REQ-029 Command 0x00 and unlisted commands: data words consumed with no effect; gp_in = 0.
REQ-030 gp_in is registered; it updates exactly one cycle after the io_strobe that determines it and holds until the next such update.
REQ-031 FIFO push while full: byte dropped; kbd_overflow <= 1 until reset.
REQ-032 FIFO push and pop in the same cycle: both succeed, occupancy unchanged, including when full.
REQ-033 FIFO pointers wrap modulo KBD_DEPTH.
REQ-034 kbd_data is valid whenever kbd_valid = 1 and comes from registers, with no combinational path from kbd_ready.
REQ-035 io_strobe coincident with io_enable falling: the strobe is ignored.

Reset
REQ-036 On reset: state IDLE; gp_in, buttons, joystick_0, status, staging, kbd_data, kbd_overflow and status_set = 0; FIFO empty (kbd_valid = 0).
REQ-037 Reset asserted mid-transaction: takes effect at the next edge; the block stays in IDLE until reset is low and io_enable is seen high.

Verification
REQ-038 enable, strobe 0x001E, 0x5678, 0x1234 -> status = 32'h12345678 one cycle after the 3rd strobe; status_set pulses once.
REQ-039 enable, strobe 0x0002, 0xAAAA, drop enable -> joystick_0 stays 0; next 0x0002, 0x0001, 0x0002 -> joystick_0 = 32'h00020001.
REQ-040 CORE_ID = 16'hBEEF; strobe 0x0032 -> gp_in = 16'hBEEF one cycle later; after the next strobe gp_in = 0.
REQ-041 kbd_ready = 0, command 0x05 plus 9 bytes 0x01..0x09 -> FIFO holds 0x01..0x08, kbd_overflow = 1, gp_in = 0 after the 8th byte.
REQ-042 FIFO full, push 0x10 with simultaneous pop -> 0x01 popped, 0x10 at tail, kbd_valid stays 1, no overflow set.
REQ-043 Reset pulsed after 0x001E and one data word -> all outputs 0; a following full 0x1E transaction commits normally.
